// File: rtl/exp_taylor_sequencer_if.sv
// Handshake and shared-FP-unit bus for exp_taylor_sequencer.
// slave: the sequencer side; master: requester plus external multiplier/adder.
interface exp_taylor_sequencer_if;
   logic        start;
   logic [31:0] x_in;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic [31:0] mul_a;
   logic [31:0] mul_b;
   logic [31:0] mul_p;
   logic [31:0] add_a;
   logic [31:0] add_b;
   logic        add_op;
   logic [31:0] add_s;

   modport slave (
      input  start, x_in, mul_p, add_s,
      output busy, done, result, mul_a, mul_b, add_a, add_b, add_op
   );

   modport master (
      output start, x_in, mul_p, add_s,
      input  busy, done, result, mul_a, mul_b, add_a, add_b, add_op
   );
endinterface

// File: rtl/exp_taylor_sequencer.sv
// Evaluates e^x as a truncated Taylor series on one shared FP multiplier and adder.
// Optional macro EXP_SPECIAL_EN: NaN/+Inf/-Inf inputs bypass the series in INIT.
module exp_taylor_sequencer #(
   parameter int N_TERMS = 6
) (
   input logic                   i_clk,
   input logic                   i_rst_n,
   exp_taylor_sequencer_if.slave io_bus
);

   generate
      if (N_TERMS < 2 || N_TERMS > 8) begin : g_bad_terms
         $error("N_TERMS must be in 2..8");
      end
   endgenerate

   localparam logic [31:0] FP_ONE = 32'h3F800000;
   localparam logic [2:0]  K_LAST = 3'(N_TERMS - 1);

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      MUL_X,
      MUL_R,
      ACC,
      FIN
   } state_t;

   state_t      r_state;
   logic [31:0] r_x;
   logic [31:0] r_term;
   logic [31:0] r_sum;
   logic [2:0]  r_k;
   logic        r_busy;
   logic        r_done;
   logic [31:0] r_result;

   logic [31:0] w_mul_a;
   logic [31:0] w_mul_b;
   logic [31:0] w_add_a;
   logic [31:0] w_add_b;
   logic        w_special;
   logic [31:0] w_special_val;

   // 1/k constants so the term recurrence needs no divider
   function automatic logic [31:0] f_recip(input logic [2:0] k);
      case (k)
         3'd2:    f_recip = 32'h3F000000;
         3'd3:    f_recip = 32'h3EAAAAAB;
         3'd4:    f_recip = 32'h3E800000;
         3'd5:    f_recip = 32'h3E4CCCCD;
         3'd6:    f_recip = 32'h3E2AAAAB;
         3'd7:    f_recip = 32'h3E124925;
         default: f_recip = 32'h00000000;
      endcase
   endfunction

`ifdef EXP_SPECIAL_EN
   logic w_exp_ff;
   logic w_is_nan;
   assign w_exp_ff  = (r_x[30:23] == 8'hFF);
   assign w_is_nan  = w_exp_ff && (r_x[22:0] != 23'd0);
   assign w_special = w_exp_ff;
   always_comb begin
      w_special_val = 32'h00000000;
      if (w_is_nan)
         w_special_val = 32'h7FC00000;
      else if (!r_x[31])
         w_special_val = 32'h7F800000;
   end
`else
   assign w_special     = 1'b0;
   assign w_special_val = 32'h00000000;
`endif

   always_comb begin
      w_mul_a = 32'd0;
      w_mul_b = 32'd0;
      w_add_a = 32'd0;
      w_add_b = 32'd0;
      case (r_state)
         INIT: begin
            if (!w_special) begin
               w_add_a = FP_ONE;
               w_add_b = r_x;
            end
         end
         MUL_X: begin
            w_mul_a = r_term;
            w_mul_b = r_x;
         end
         MUL_R: begin
            w_mul_a = r_term;
            w_mul_b = f_recip(r_k);
         end
         ACC: begin
            w_add_a = r_sum;
            w_add_b = r_term;
         end
         default: ;
      endcase
   end

   assign io_bus.mul_a  = w_mul_a;
   assign io_bus.mul_b  = w_mul_b;
   assign io_bus.add_a  = w_add_a;
   assign io_bus.add_b  = w_add_b;
   assign io_bus.add_op = 1'b1;
   assign io_bus.busy   = r_busy;
   assign io_bus.done   = r_done;
   assign io_bus.result = r_result;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= IDLE;
         r_x      <= 32'd0;
         r_term   <= 32'd0;
         r_sum    <= 32'd0;
         r_k      <= 3'd0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_result <= 32'd0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (io_bus.start) begin
                  r_x     <= io_bus.x_in;
                  r_busy  <= 1'b1;
                  r_state <= INIT;
               end
            end
            INIT: begin
               if (w_special) begin
                  r_sum   <= w_special_val;
                  r_busy  <= 1'b0;
                  r_state <= FIN;
               end else begin
                  r_sum  <= io_bus.add_s;
                  r_term <= r_x;
                  r_k    <= 3'd2;
                  // two-term series is complete after 1 + x
                  if (N_TERMS == 2) begin
                     r_busy  <= 1'b0;
                     r_state <= FIN;
                  end else begin
                     r_state <= MUL_X;
                  end
               end
            end
            MUL_X: begin
               r_term  <= io_bus.mul_p;
               r_state <= MUL_R;
            end
            MUL_R: begin
               r_term  <= io_bus.mul_p;
               r_state <= ACC;
            end
            ACC: begin
               r_sum <= io_bus.add_s;
               if (r_k == K_LAST) begin
                  r_busy  <= 1'b0;
                  r_state <= FIN;
               end else begin
                  r_k     <= r_k + 3'd1;
                  r_state <= MUL_X;
               end
            end
            FIN: begin
               r_result <= r_sum;
               r_done   <= 1'b1;
               r_state  <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_exp_taylor_sequencer.sv
// Directed bench for exp_taylor_sequencer; FP units modelled through double precision.
// Honours EXP_SPECIAL_EN the same way as the design.
module tb_exp_taylor_sequencer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   exp_taylor_sequencer_if bus ();

   exp_taylor_sequencer #(.N_TERMS(6)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .io_bus  (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;

   function automatic logic [63:0] f2d(input logic [31:0] b);
      logic [10:0] e;
      if (b[30:23] == 8'hFF) return {b[31], 11'h7FF, b[22:0], 29'b0};
      if (b[30:23] == 8'h00) return {b[31], 63'b0};
      e = 11'(b[30:23]) + 11'd896;
      return {b[31], e, b[22:0], 29'b0};
   endfunction

   function automatic logic [31:0] d2f(input logic [63:0] d);
      int          ee;
      logic [23:0] mr;
      logic [28:0] rem;
      if (d[62:52] == 11'h7FF) return (d[51:0] != 52'd0) ? 32'h7FC00000 : {d[63], 8'hFF, 23'b0};
      if (d[62:52] == 11'h000) return {d[63], 31'b0};
      ee  = int'(d[62:52]) - 896;
      mr  = {1'b0, d[51:29]};
      rem = d[28:0];
      if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && mr[0])) mr = mr + 24'd1;
      if (mr[23]) begin
         mr = 24'd0;
         ee++;
      end
      if (ee >= 255) return {d[63], 8'hFF, 23'b0};
      if (ee <= 0) return {d[63], 31'b0};
      return {d[63], 8'(ee), mr[22:0]};
   endfunction

   // external single-precision multiplier and adder, combinational
   always_comb begin
      bus.mul_p = d2f($realtobits($bitstoreal(f2d(bus.mul_a)) * $bitstoreal(f2d(bus.mul_b))));
      bus.add_s = d2f($realtobits($bitstoreal(f2d(bus.add_a)) + $bitstoreal(f2d(bus.add_b))));
   end

   function automatic logic [31:0] ulp_ok(input logic [31:0] a, input logic [31:0] b);
      int diff;
      diff = int'(a) - int'(b);
      if (diff < 0) diff = -diff;
      return (diff <= 2) ? 32'd1 : 32'd0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Called #1 after a rising edge; start is sampled on the next edge.
   task automatic run(input logic [31:0] x, input int inj_at, input logic [31:0] inj_x,
                      output int lat, output int bcnt, output logic [31:0] res);
      bus.start = 1'b1;
      bus.x_in  = x;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.x_in  = 32'hDEADBEEF;
      lat  = 0;
      bcnt = bus.busy ? 1 : 0;
      res  = 32'hXXXXXXXX;
      while (lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
         if (lat == inj_at) begin
            bus.start = 1'b1;
            bus.x_in  = inj_x;
         end else begin
            bus.start = 1'b0;
         end
         if (bus.done) begin
            res = bus.result;
            break;
         end
         if (bus.busy) bcnt++;
      end
   endtask

   initial begin
      int          lat, bc, lat2, bc2;
      logic [31:0] res, res2;
      logic        acc;
      bus.start = 1'b0;
      bus.x_in  = 32'd0;

      #12;
      chk("rst_busy",   32'(bus.busy),   32'd0);
      chk("rst_done",   32'(bus.done),   32'd0);
      chk("rst_result", bus.result,      32'd0);
      chk("rst_mul_a",  bus.mul_a,       32'd0);
      chk("rst_add_b",  bus.add_b,       32'd0);
      chk("rst_add_op", 32'(bus.add_op), 32'd1);
      @(posedge clk);
      #1 rst_n = 1'b1;

      run(32'h00000000, -1, 32'd0, lat, bc, res);
      chk("zero_latency", 32'(lat), 32'd14);
      chk("zero_busy",    32'(bc),  32'd13);
      chk("zero_result",  res,      32'h3F800000);

      run(32'h3F800000, -1, 32'd0, lat, bc, res);
      chk("one_latency", 32'(lat),        32'd14);
      chk("one_ulp",     ulp_ok(res, 32'h402DDDDD), 32'd1);

      run(32'hBF800000, -1, 32'd0, lat, bc, res);
      chk("neg1_ulp", ulp_ok(res, 32'h3EBBBBBC), 32'd1);

      // start pulsed mid-run must be dropped
      run(32'h00000000, 5, 32'h3F800000, lat, bc, res);
      chk("ign_latency", 32'(lat), 32'd14);
      chk("ign_result",  res,      32'h3F800000);
      acc = 1'b0;
      repeat (4) begin
         @(posedge clk);
         #1 acc = acc | bus.done | bus.busy;
      end
      chk("ign_no_rerun", 32'(acc), 32'd0);

      // back-to-back: second start issued in the done cycle
      run(32'h3F800000, -1, 32'd0, lat, bc, res);
      run(32'h00000000, -1, 32'd0, lat2, bc2, res2);
      chk("b2b_first",   ulp_ok(res, 32'h402DDDDD), 32'd1);
      chk("b2b_latency", 32'(lat2), 32'd14);
      chk("b2b_result",  res2,      32'h3F800000);

      // abort in MUL_R
      bus.start = 1'b1;
      bus.x_in  = 32'hBF800000;
      @(posedge clk);
      #1 bus.start = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk("mulr_operand", bus.mul_b, 32'h3F000000);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy",   32'(bus.busy), 32'd0);
      chk("abort_result", bus.result,    32'd0);
      chk("abort_mul_a",  bus.mul_a,     32'd0);
      chk("abort_mul_b",  bus.mul_b,     32'd0);
      acc = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1 acc = acc | bus.done;
      end
      chk("abort_no_done", 32'(acc), 32'd0);
      rst_n = 1'b1;
      run(32'h00000000, -1, 32'd0, lat, bc, res);
      chk("post_abort_latency", 32'(lat), 32'd14);
      chk("post_abort_result",  res,      32'h3F800000);

`ifdef EXP_SPECIAL_EN
      run(32'h7F800000, -1, 32'd0, lat, bc, res);
      chk("pinf_latency", 32'(lat), 32'd2);
      chk("pinf_result",  res,      32'h7F800000);
      run(32'h7FC00001, -1, 32'd0, lat, bc, res);
      chk("nan_latency", 32'(lat), 32'd2);
      chk("nan_result",  res,      32'h7FC00000);
      run(32'hFF800000, -1, 32'd0, lat, bc, res);
      chk("ninf_result", res, 32'h00000000);
`else
      run(32'h7F800000, -1, 32'd0, lat, bc, res);
      chk("pinf_latency", 32'(lat), 32'd14);
      run(32'h7FC00001, -1, 32'd0, lat, bc, res);
      chk("nan_latency", 32'(lat), 32'd14);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/exp_taylor_sequencer.md
# exp_taylor_sequencer

Time-multiplexed controller that evaluates e^x as a truncated Taylor series using one shared single-precision multiplier and one shared adder. It replaces the fully unrolled exponential datapath in the activation path. The block owns the schedule, operand muxing and accumulator registers; the FP units sit outside it and are reached through operand and result ports. Term recurrence uses constant reciprocals, term_k = term_(k-1) · x · (1/k), so no divider is needed.

## Interface
- N_TERMS, 6, highest power of x evaluated plus one; legal range 2..8 (series 1 + x + … + x^(N_TERMS-1)/(N_TERMS-1)!).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- x_in  input  32  IEEE-754 single operand, latched on accepted start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse; result valid in the same cycle.
- result  output  32  e^x estimate; held until the next accepted start.
- mul_a, mul_b  output  32 each  multiplier operands.
- mul_p  input  32  multiplier product (combinational from mul_a/mul_b).
- add_a, add_b  output  32 each  adder operands.
- add_op  output  1  adder mode; constant 1 (add).
- add_s  input  32  adder sum (combinational).

## Operation
- Registers: x_r, term_r, sum_r, k (3-bit term index), state.
- States: IDLE, INIT, MUL_X, MUL_R, ACC, FIN.
- IDLE: start=1 → latch x_r=x_in, go INIT. All unit operands are 0.
- INIT: add_a=0x3F800000, add_b=x_r; capture sum_r=add_s, term_r=x_r, k=2 → MUL_X.
- MUL_X: mul_a=term_r, mul_b=x_r; capture term_r=mul_p → MUL_R.
- MUL_R: mul_a=term_r, mul_b=RECIP[k]; capture term_r=mul_p → ACC.
- RECIP table: 2:0x3F000000, 3:0x3EAAAAAB, 4:0x3E800000, 5:0x3E4CCCCD, 6:0x3E2AAAAB, 7:0x3E124925, 8:0x3E000000.
- ACC: add_a=sum_r, add_b=term_r; capture sum_r=add_s. If k==N_TERMS-1 → FIN, else k=k+1 → MUL_X.
- FIN: result=sum_r, done=1 → IDLE.
- Operands not listed for a state are driven to 0. Operands are decoded from state and registers. Unit results are captured on the rising edge that ends the state.
- start while busy is ignored; there is no queueing. x_in changes after acceptance have no effect.

## Timing
- Latency from the start-sampling edge to done: 1 (INIT) + 3·(N_TERMS−2) + 1 (FIN). With the default, that is 14 cycles. The next start is accepted in the cycle after done.
- Reset values: busy=0, done=0, result=0, all operand outputs=0, add_op=1, state=IDLE, k=0.
- rst_n low mid-computation aborts immediately: no done pulse, result forced to 0.
- The shared units must settle within one clk period. No pipelined-unit support.

## Configuration
- EXP_SPECIAL_EN defined: in INIT, x_r is checked for special values.
  - NaN → result 0x7FC00000.
  - +Inf → 0x7F800000.
  - −Inf → 0x00000000.
  - For these inputs the block goes straight to FIN; done arrives 2 cycles after start and the units see only zero operands.
- EXP_SPECIAL_EN undefined: every input follows the full schedule. Output for special inputs is whatever the units produce.

## Test plan
- x_in=0x00000000, N_TERMS=6 → done exactly 14 cycles after start; result=0x3F800000; busy high for 13 cycles.
- x_in=0x3F800000 (1.0) → result within 2 ulp of 0x402DDDDD (2.716667).
- x_in=0xBF800000 (−1.0) → result within 2 ulp of 0x3EBBBBBC (0.366667).
- A second start pulsed 5 cycles into a run → ignored; one done; result matches the first x_in. A back-to-back start in the cycle after done is accepted.
- rst_n pulled low in MUL_R → all outputs 0 asynchronously; no done. A new start after release completes normally.
- With EXP_SPECIAL_EN: x_in=0x7F800000 → result 0x7F800000, done 2 cycles after start. x_in=0x7FC00001 → result 0x7FC00000. Without the macro, the same stimulus takes 14 cycles.
